// File: rtl/pacman_move_ctrl.sv
// Pac-Man move controller: proposes a one-tile step per tick, wall/dot checks it.
// Optional tunnel wrap at map edges under `define PACMAN_TUNNEL_WRAP_EN.
module pacman_move_ctrl #(
  parameter int         MAP_W     = 40,
  parameter int         MAP_H     = 30,
  parameter logic [5:0] START_X   = 6'd19,
  parameter logic [4:0] START_Y   = 5'd22,
  parameter logic [3:0] WALL_CODE = 4'd1,
  parameter logic [3:0] DOT_CODE  = 4'd2
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               up,
  input  logic               down,
  input  logic               left,
  input  logic               right,
  input  logic               tick,
  input  logic               done,
  input  logic [4*MAP_W-1:0] rd_q,
  output logic [4:0]         rd_addr,
  output logic [5:0]         curr_pacman_x,
  output logic [4:0]         curr_pacman_y,
  output logic [5:0]         next_pacman_x,
  output logic [4:0]         next_pacman_y,
  output logic               busy,
  output logic               dot_eaten,
  output logic               blocked
);

  typedef enum logic [1:0] {
    IDLE, FETCH, CHECK, COMMIT
  } state_t;

  localparam logic [1:0] D_UP = 2'd0;
  localparam logic [1:0] D_DN = 2'd1;
  localparam logic [1:0] D_LT = 2'd2;
  localparam logic [1:0] D_RT = 2'd3;

  localparam logic [5:0] X_MAX = 6'(MAP_W - 1);
  localparam logic [4:0] Y_MAX = 5'(MAP_H - 1);

  state_t       state;
  logic [1:0]   held_dir;
  logic         dir_v;
  logic [5:0]   cand_x;
  logic [4:0]   cand_y;
  logic         cand_off;
  logic [5:0]   step_x;
  logic [4:0]   step_y;
  logic         step_off;
  logic [4*MAP_W-1:0] row_sh;
  logic [3:0]   tile;

  // Candidate step from the held direction (pre-update value on a tick edge)
  always_comb begin
    step_x   = curr_pacman_x;
    step_y   = curr_pacman_y;
    step_off = 1'b0;
    unique case (held_dir)
      D_UP: begin
        if (curr_pacman_y == 5'd0) begin
`ifdef PACMAN_TUNNEL_WRAP_EN
          step_y = Y_MAX;
`else
          step_off = 1'b1;
`endif
        end else begin
          step_y = curr_pacman_y - 5'd1;
        end
      end
      D_DN: begin
        if (curr_pacman_y == Y_MAX) begin
`ifdef PACMAN_TUNNEL_WRAP_EN
          step_y = 5'd0;
`else
          step_off = 1'b1;
`endif
        end else begin
          step_y = curr_pacman_y + 5'd1;
        end
      end
      D_LT: begin
        if (curr_pacman_x == 6'd0) begin
`ifdef PACMAN_TUNNEL_WRAP_EN
          step_x = X_MAX;
`else
          step_off = 1'b1;
`endif
        end else begin
          step_x = curr_pacman_x - 6'd1;
        end
      end
      D_RT: begin
        if (curr_pacman_x == X_MAX) begin
`ifdef PACMAN_TUNNEL_WRAP_EN
          step_x = 6'd0;
`else
          step_off = 1'b1;
`endif
        end else begin
          step_x = curr_pacman_x + 6'd1;
        end
      end
    endcase
  end

  // Column 0 sits in the top nibble of the row word
  always_comb begin
    row_sh = rd_q << {cand_x, 2'b00};
    tile   = row_sh[4*MAP_W-1 -: 4];
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      held_dir      <= D_UP;
      dir_v         <= 1'b0;
      cand_x        <= START_X;
      cand_y        <= START_Y;
      cand_off      <= 1'b0;
      rd_addr       <= START_Y;
      curr_pacman_x <= START_X;
      curr_pacman_y <= START_Y;
      next_pacman_x <= START_X;
      next_pacman_y <= START_Y;
      busy          <= 1'b0;
      dot_eaten     <= 1'b0;
      blocked       <= 1'b0;
    end else begin
      dot_eaten <= 1'b0;
      blocked   <= 1'b0;
      if (up) begin
        held_dir <= D_UP;
        dir_v    <= 1'b1;
      end else if (down) begin
        held_dir <= D_DN;
        dir_v    <= 1'b1;
      end else if (left) begin
        held_dir <= D_LT;
        dir_v    <= 1'b1;
      end else if (right) begin
        held_dir <= D_RT;
        dir_v    <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (tick && dir_v) begin
            cand_x   <= step_x;
            cand_y   <= step_y;
            cand_off <= step_off;
            rd_addr  <= step_y;
            busy     <= 1'b1;
            state    <= FETCH;
          end
        end
        FETCH: state <= CHECK;
        CHECK: begin
          if (cand_off || tile == WALL_CODE) begin
            blocked <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end else begin
            next_pacman_x <= cand_x;
            next_pacman_y <= cand_y;
            dot_eaten     <= (tile == DOT_CODE);
            state         <= COMMIT;
          end
        end
        COMMIT: begin
          if (done) begin
            curr_pacman_x <= next_pacman_x;
            curr_pacman_y <= next_pacman_y;
            busy          <= 1'b0;
            state         <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pacman_move_ctrl.sv
// Directed bench for pacman_move_ctrl with a one-cycle-latency map RAM model.
// Expected edge behaviour follows PACMAN_TUNNEL_WRAP_EN.
module tb_pacman_move_ctrl;

  localparam logic [3:0] K_UP = 4'b1000;
  localparam logic [3:0] K_DN = 4'b0100;
  localparam logic [3:0] K_LT = 4'b0010;
  localparam logic [3:0] K_RT = 4'b0001;

  logic         CLOCK_50 = 1'b0;
  logic         reset;
  logic         up, down, left, right;
  logic         tick, done;
  logic [159:0] rd_q = '0;
  logic [4:0]   rd_addr;
  logic [5:0]   curr_pacman_x, next_pacman_x;
  logic [4:0]   curr_pacman_y, next_pacman_y;
  logic         busy, dot_eaten, blocked;

  logic [159:0] map [0:29];
  int passed = 0;
  int total  = 0;
  int px, py;

  typedef struct {
    logic [3:0] keys;
    bit         same;
    int         ex;
    int         ey;
    bit         eblk;
    bit         edot;
    int         erd;
  } vec_t;
  vec_t tbl [3];

  pacman_move_ctrl dut (
    .CLOCK_50      (CLOCK_50),
    .reset         (reset),
    .up            (up),
    .down          (down),
    .left          (left),
    .right         (right),
    .tick          (tick),
    .done          (done),
    .rd_q          (rd_q),
    .rd_addr       (rd_addr),
    .curr_pacman_x (curr_pacman_x),
    .curr_pacman_y (curr_pacman_y),
    .next_pacman_x (next_pacman_x),
    .next_pacman_y (next_pacman_y),
    .busy          (busy),
    .dot_eaten     (dot_eaten),
    .blocked       (blocked)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50)
    rd_q <= (rd_addr < 5'd30) ? map[rd_addr] : '0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic set_keys(input logic [3:0] k);
    {up, down, left, right} = k;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_curr_x"}, curr_pacman_x, 19);
    chk({tag, "_curr_y"}, curr_pacman_y, 22);
    chk({tag, "_next_x"}, next_pacman_x, 19);
    chk({tag, "_next_y"}, next_pacman_y, 22);
    chk({tag, "_rd_addr"}, rd_addr, 22);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_dot"}, dot_eaten, 0);
    chk({tag, "_blocked"}, blocked, 0);
  endtask

  task automatic move(input logic [3:0] keys, input bit same,
                      input int ex, input int ey, input bit eblk,
                      input bit edot, input int erd);
    if (!same && keys != 4'd0) begin
      @(negedge CLOCK_50) set_keys(keys);
      @(negedge CLOCK_50) set_keys(4'd0);
    end
    @(negedge CLOCK_50);
    tick = 1'b1;
    if (same) set_keys(keys);
    @(negedge CLOCK_50);
    tick = 1'b0;
    set_keys(4'd0);
    chk("fetch_busy", busy, 1);
    chk("fetch_rd_addr", rd_addr, erd);
    @(negedge CLOCK_50);
    chk("check_next_x", next_pacman_x, px);
    @(negedge CLOCK_50);
    chk("res_next_x", next_pacman_x, ex);
    chk("res_next_y", next_pacman_y, ey);
    chk("res_blocked", blocked, eblk);
    chk("res_dot", dot_eaten, edot);
    chk("res_busy", busy, !eblk);
    if (!eblk) begin
      chk("commit_curr_x", curr_pacman_x, px);
      chk("commit_curr_y", curr_pacman_y, py);
      done = 1'b1;
      @(negedge CLOCK_50);
      done = 1'b0;
      chk("done_curr_x", curr_pacman_x, ex);
      chk("done_curr_y", curr_pacman_y, ey);
      chk("done_busy", busy, 0);
      chk("dot_pulse_end", dot_eaten, 0);
      px = ex;
      py = ey;
    end else begin
      @(negedge CLOCK_50);
      chk("blk_pulse_end", blocked, 0);
      chk("blk_next_x", next_pacman_x, px);
    end
  endtask

  initial begin
    int ex;
    bit eblk;
    reset = 1'b1;
    tick  = 1'b0;
    done  = 1'b0;
    set_keys(4'd0);
    for (int r = 0; r < 30; r++) map[r] = '0;
    map[21][156-4*20 +: 4] = 4'd1;
    map[23][156-4*20 +: 4] = 4'd2;

    tbl[0] = '{K_RT, 1'b0, 20, 22, 1'b0, 1'b0, 22};
    tbl[1] = '{K_UP | K_DN, 1'b0, 20, 22, 1'b1, 1'b0, 21};
    tbl[2] = '{K_DN | K_LT, 1'b0, 20, 23, 1'b0, 1'b1, 23};

    repeat (2) @(negedge CLOCK_50);
    chk_reset("in_reset");
    reset = 1'b0;
    @(negedge CLOCK_50);
    chk_reset("post_reset");

    tick = 1'b1;
    @(negedge CLOCK_50);
    tick = 1'b0;
    chk("nokey_busy", busy, 0);
    repeat (3) @(negedge CLOCK_50);
    chk_reset("nokey");
    px = 19;
    py = 22;

    for (int i = 0; i < 3; i++)
      move(tbl[i].keys, tbl[i].same, tbl[i].ex, tbl[i].ey,
           tbl[i].eblk, tbl[i].edot, tbl[i].erd);

    // Walk to (0,14); last left step has up pressed with the tick
    for (int i = 0; i < 20; i++)
      move((i == 0) ? K_LT : ((i == 19) ? K_UP : 4'd0),
           (i == 19), 19 - i, 23, 1'b0, 1'b0, 23);
    for (int i = 0; i < 9; i++)
      move(4'd0, 1'b0, 0, 22 - i, 1'b0, 1'b0, 22 - i);

`ifdef PACMAN_TUNNEL_WRAP_EN
    ex   = 39;
    eblk = 1'b0;
`else
    ex   = 0;
    eblk = 1'b1;
`endif
    move(K_LT, 1'b0, ex, 14, eblk, 1'b0, 14);

    // Reset while in COMMIT
    @(negedge CLOCK_50) reset = 1'b1;
    @(negedge CLOCK_50) reset = 1'b0;
    px = 19;
    py = 22;
    move(K_RT, 1'b0, 20, 22, 1'b0, 1'b0, 22);
    @(negedge CLOCK_50) tick = 1'b1;
    @(negedge CLOCK_50) tick = 1'b0;
    repeat (2) @(negedge CLOCK_50);
    chk("pre_rst_next_x", next_pacman_x, 21);
    chk("pre_rst_next_y", next_pacman_y, 22);
    chk("pre_rst_busy", busy, 1);
    #2 reset = 1'b1;
    #1 chk_reset("async_rst");
    @(negedge CLOCK_50);
    reset = 1'b0;
    done  = 1'b1;
    @(negedge CLOCK_50);
    done = 1'b0;
    @(negedge CLOCK_50);
    chk_reset("late_done");

    // Ticks while busy are dropped
    set_keys(K_RT);
    @(negedge CLOCK_50);
    set_keys(4'd0);
    tick = 1'b1;
    repeat (3) @(negedge CLOCK_50);
    tick = 1'b0;
    chk("drop_next_x", next_pacman_x, 20);
    chk("drop_busy", busy, 1);
    done = 1'b1;
    @(negedge CLOCK_50);
    done = 1'b0;
    chk("drop_curr_x", curr_pacman_x, 20);
    for (int i = 0; i < 4; i++) begin
      @(negedge CLOCK_50);
      chk("drop_idle_busy", busy, 0);
      chk("drop_idle_next", next_pacman_x, 20);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
